// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter and the blocks around it
// (VGA scan-out, memory). Source ids: channels are 0..N_CH-1, video is N_CH.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_CH     = 8;

    // Width of a source id able to name every channel plus video.
    function automatic int src_w(input int n_ch);
        return $clog2(n_ch + 1);
    endfunction

    // Source id used for the video read port.
    function automatic int vid_src(input int n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// N-input round-robin pick. The search starts at ptr and wraps; ptr moves
// to one past the winner only when the caller says the pick was used.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [IDX_W-1:0] ptr;

    // First requester at or after ptr; descending loop lets the lowest offset win.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_idx   = IDX_W'((int'(ptr) + k) % N);
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) gnt[gnt_idx] = 1'b1;
    end

    // Pointer advances past the winner only on a used round-robin grant.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            ptr <= '0;
        end else if (advance && gnt_valid) begin
            ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: video reads have priority, general channels
// are served round-robin, and a per-channel wait counter lets a starved
// channel preempt video. Read data returns MEM_LAT cycles after the grant,
// routed by a tag pipeline that remembers who issued each read.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int N_CH       = 2,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vid_req,
    input  logic [ADDR_W-1:0]        vid_addr,
    output logic                     vid_gnt,
    output logic                     vid_rvalid,
    output logic [DATA_W-1:0]        vid_rdata,
    output logic                     vid_stall,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    output logic [N_CH-1:0]          ch_gnt,
    output logic [N_CH-1:0]          ch_rvalid,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int SRC_W = src_w(N_CH);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);
    localparam logic [SRC_W-1:0] VID = SRC_W'(vid_src(N_CH));

    typedef struct packed {
        logic             valid;
        logic [SRC_W-1:0] src;
    } tag_t;

    logic [CNT_W-1:0]  wait_cnt [N_CH];
    logic              starve_any;
    logic [IDX_W-1:0]  starve_idx;
    logic [N_CH-1:0]   rr_gnt;
    logic [IDX_W-1:0]  rr_idx;
    logic              rr_valid;
    logic              rr_adv;
    logic [IDX_W-1:0]  win_ch;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_wdata;
    tag_t              tag_q [MEM_LAT];
    tag_t              tag_out;

    rr_arbiter #(.N(N_CH)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (ch_req),
        .advance   (rr_adv),
        .gnt       (rr_gnt),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

    // Lowest-index channel that is still requesting and has waited the limit.
    always_comb begin
        starve_any = 1'b0;
        starve_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_req[i] && wait_cnt[i] == CNT_W'(STARVE_LIM)) begin
                starve_any = 1'b1;
                starve_idx = IDX_W'(i);
            end
        end
    end

    // Priority: starved channel, then video, then round-robin; nothing while in reset.
    always_comb begin
        vid_gnt   = 1'b0;
        vid_stall = 1'b0;
        ch_gnt    = '0;
        rr_adv    = 1'b0;
        win_ch    = starve_any ? starve_idx : rr_idx;
        if (!reset) begin
            if (starve_any) begin
                ch_gnt[starve_idx] = 1'b1;
                vid_stall          = vid_req;
            end else if (vid_req) begin
                vid_gnt = 1'b1;
            end else if (rr_valid) begin
                ch_gnt = rr_gnt;
                rr_adv = 1'b1;
            end
        end
    end

    // Memory command from the winner; an idle cycle keeps the previous address.
    always_comb begin
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        mem_we    = 1'b0;
        if (vid_gnt) begin
            mem_addr = vid_addr;
        end else if (|ch_gnt) begin
            mem_addr  = ch_addr[int'(win_ch)*ADDR_W +: ADDR_W];
            mem_wdata = ch_wdata[int'(win_ch)*DATA_W +: DATA_W];
            mem_we    = ch_we[win_ch];
        end
    end

    // Remember the last command so an idle port holds its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    // Wait counters: count while pending and not granted, clear otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_req[i] && !ch_gnt[i]) begin
                    if (wait_cnt[i] != CNT_W'(STARVE_LIM)) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    // Tag pipeline follows each granted read through the memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this small array is reset on purpose so reads in flight at reset never surface; bulk storage arrays would not be.
            for (int s = 0; s < MEM_LAT; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0].valid <= (vid_gnt || (|ch_gnt)) && !mem_we;
            tag_q[0].src   <= vid_gnt ? VID : SRC_W'(win_ch);
            for (int s = 1; s < MEM_LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign tag_out = tag_q[MEM_LAT-1];

    // Route returning data to its issuer; data buses read zero when not valid.
    always_comb begin
        vid_rvalid = tag_out.valid && (tag_out.src == VID);
        for (int i = 0; i < N_CH; i++) begin
            ch_rvalid[i] = tag_out.valid && (tag_out.src == SRC_W'(i));
        end
        vid_rdata = vid_rvalid ? mem_rdata : '0;
        ch_rdata  = (|ch_rvalid) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
// Each has a small behavioural memory preloaded with a known pattern.
module tb_mem_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          a_vid_req, a_vid_gnt, a_vid_rvalid, a_vid_stall;
    logic [AW-1:0] a_vid_addr, a_mem_addr;
    logic [DW-1:0] a_vid_rdata, a_ch_rdata, a_mem_wdata, a_mem_rdata;
    logic [NC-1:0] a_ch_req, a_ch_we, a_ch_gnt, a_ch_rvalid;
    logic [NC*AW-1:0] a_ch_addr;
    logic [NC*DW-1:0] a_ch_wdata;
    logic          a_mem_we;

    logic          b_vid_req, b_vid_gnt, b_vid_rvalid, b_vid_stall;
    logic [AW-1:0] b_vid_addr, b_mem_addr;
    logic [DW-1:0] b_vid_rdata, b_ch_rdata, b_mem_wdata, b_mem_rdata;
    logic [NC-1:0] b_ch_req, b_ch_we, b_ch_gnt, b_ch_rvalid;
    logic [NC*AW-1:0] b_ch_addr;
    logic [NC*DW-1:0] b_ch_wdata;
    logic          b_mem_we;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC), .MEM_LAT(1), .STARVE_LIM(8)) dut_a (
        .clk(clk), .reset(reset),
        .vid_req(a_vid_req), .vid_addr(a_vid_addr), .vid_gnt(a_vid_gnt),
        .vid_rvalid(a_vid_rvalid), .vid_rdata(a_vid_rdata), .vid_stall(a_vid_stall),
        .ch_req(a_ch_req), .ch_we(a_ch_we), .ch_addr(a_ch_addr), .ch_wdata(a_ch_wdata),
        .ch_gnt(a_ch_gnt), .ch_rvalid(a_ch_rvalid), .ch_rdata(a_ch_rdata),
        .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC), .MEM_LAT(3), .STARVE_LIM(8)) dut_b (
        .clk(clk), .reset(reset),
        .vid_req(b_vid_req), .vid_addr(b_vid_addr), .vid_gnt(b_vid_gnt),
        .vid_rvalid(b_vid_rvalid), .vid_rdata(b_vid_rdata), .vid_stall(b_vid_stall),
        .ch_req(b_ch_req), .ch_we(b_ch_we), .ch_addr(b_ch_addr), .ch_wdata(b_ch_wdata),
        .ch_gnt(b_ch_gnt), .ch_rvalid(b_ch_rvalid), .ch_rdata(b_ch_rdata),
        .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Behavioural memories: a has one cycle of read latency, b has three.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] b_p0, b_p1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'hA000 + 16'(i);
            mem_b[i] = 16'hB000 + 16'(i);
        end
    end

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        a_mem_rdata <= mem_a[a_mem_addr[7:0]];
        if (b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        b_p0        <= mem_b[b_mem_addr[7:0]];
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_all();
        a_vid_req = 1'b0; a_vid_addr = '0; a_ch_req = '0; a_ch_we = '0; a_ch_addr = '0; a_ch_wdata = '0;
        b_vid_req = 1'b0; b_vid_addr = '0; b_ch_req = '0; b_ch_we = '0; b_ch_addr = '0; b_ch_wdata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    logic [NC-1:0] exp_g, prev_g;

    initial begin
        // Reset with requests asserted: nothing may be granted.
        idle_all();
        reset = 1'b1;
        a_vid_req = 1'b1; a_ch_req = 2'b11; b_vid_req = 1'b1; b_ch_req = 2'b01;
        repeat (2) @(negedge clk);
        #1;
        check("rst_vid_gnt", a_vid_gnt, 0);
        check("rst_ch_gnt", a_ch_gnt, 0);
        check("rst_mem_addr", a_mem_addr, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        check("rst_rvalid", {a_vid_rvalid, a_ch_rvalid}, 0);
        check("rst_stall", a_vid_stall, 0);
        check("rst_rdata", {a_vid_rdata, a_ch_rdata}, 0);
        check("rst_b_gnt", {b_vid_gnt, b_ch_gnt}, 0);
        @(negedge clk);
        idle_all();
        reset = 1'b0;

        // Video reads 0..3 back to back, data one cycle later.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_vid_req  = (i < 4);
            a_vid_addr = AW'(i);
            #1;
            if (i < 4) begin
                check("vid_gnt", a_vid_gnt, 1);
                check("vid_mem_addr", a_mem_addr, i);
            end
            if (i > 0) begin
                check("vid_rvalid", a_vid_rvalid, 1);
                check("vid_rdata", a_vid_rdata, 16'hA000 + i - 1);
            end
        end
        @(negedge clk);
        #1 check("vid_rvalid_end", a_vid_rvalid, 0);

        // Channel 0 write then read of the same address.
        @(negedge clk);
        a_ch_req = 2'b01; a_ch_we = 2'b01;
        a_ch_addr[0 +: AW] = 15'h0100; a_ch_wdata[0 +: DW] = 16'h1234;
        #1;
        check("wr_gnt", a_ch_gnt, 2'b01);
        check("wr_mem_we", a_mem_we, 1);
        check("wr_mem_addr", a_mem_addr, 15'h0100);
        check("wr_mem_wdata", a_mem_wdata, 16'h1234);
        @(negedge clk);
        a_ch_we = 2'b00;
        #1;
        check("rd_gnt", a_ch_gnt, 2'b01);
        check("rd_mem_we", a_mem_we, 0);
        check("wr_no_rvalid", a_ch_rvalid, 0);
        @(negedge clk);
        idle_all();
        #1;
        check("rd_rvalid", a_ch_rvalid, 2'b01);
        check("rd_rdata", a_ch_rdata, 16'h1234);
        @(negedge clk);
        #1 check("idle_mem_addr_held", a_mem_addr, 15'h0100);

        // Round robin from a fresh reset: 0,1,0,1.
        pulse_reset();
        prev_g = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_ch_req = 2'b11;
            a_ch_addr = {15'h0006, 15'h0005};
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check("rr_gnt", a_ch_gnt, exp_g);
            if (i > 0) begin
                check("rr_rvalid", a_ch_rvalid, prev_g);
                check("rr_rdata", a_ch_rdata, (prev_g == 2'b01) ? 16'hA005 : 16'hA006);
            end
            prev_g = exp_g;
        end
        @(negedge clk);
        idle_all();
        #1;
        check("rr_rvalid_last", a_ch_rvalid, 2'b10);
        check("rr_rdata_last", a_ch_rdata, 16'hA006);

        // Starvation: ch1 drops after 5 waits (counter clears), then waits 8 and wins on the 9th.
        a_vid_req = 1'b1; a_vid_addr = 15'h0020; a_ch_addr = {15'h0030, 15'h0000};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_ch_req = (k < 5) ? 2'b10 : 2'b00;
            #1 check("pre_drop_ch_gnt", a_ch_gnt, 0);
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            a_ch_req = 2'b10;
            #1;
            check("starve_ch_gnt", a_ch_gnt, (k == 9) ? 2'b10 : 2'b00);
            check("starve_vid_gnt", a_vid_gnt, (k == 9) ? 0 : 1);
            check("starve_stall", a_vid_stall, (k == 9) ? 1 : 0);
            if (k == 9) check("starve_mem_addr", a_mem_addr, 15'h0030);
        end
        @(negedge clk);
        a_ch_req = 2'b00;
        #1;
        check("post_starve_vid_gnt", a_vid_gnt, 1);
        check("post_starve_stall", a_vid_stall, 0);
        @(negedge clk);
        idle_all();

        // MEM_LAT=3: mixed video/ch0 reads; a ch0 read on a moves its pointer to 1.
        @(negedge clk);
        b_vid_req = 1'b1; b_vid_addr = 15'h0010;
        a_ch_req = 2'b01; a_ch_addr = {15'h0000, 15'h0005};
        #1;
        check("l3_vid_gnt0", b_vid_gnt, 1);
        check("a_ptr_move_gnt", a_ch_gnt, 2'b01);
        @(negedge clk);
        idle_all();
        b_ch_req = 2'b01; b_ch_addr = {15'h0000, 15'h0020};
        #1;
        check("l3_ch_gnt1", b_ch_gnt, 2'b01);
        check("l3_none1", {b_vid_rvalid, b_ch_rvalid}, 0);
        @(negedge clk);
        b_ch_req = 2'b00; b_vid_req = 1'b1; b_vid_addr = 15'h0011;
        #1;
        check("l3_vid_gnt2", b_vid_gnt, 1);
        check("l3_none2", {b_vid_rvalid, b_ch_rvalid}, 0);
        @(negedge clk);
        idle_all();
        #1;
        check("l3_rv_vid0", {b_vid_rvalid, b_ch_rvalid}, 3'b100);
        check("l3_rd_vid0", b_vid_rdata, 16'hB010);
        @(negedge clk);
        #1;
        check("l3_rv_ch", {b_vid_rvalid, b_ch_rvalid}, 3'b001);
        check("l3_rd_ch", b_ch_rdata, 16'hB020);
        @(negedge clk);
        #1;
        check("l3_rv_vid2", {b_vid_rvalid, b_ch_rvalid}, 3'b100);
        check("l3_rd_vid2", b_vid_rdata, 16'hB011);
        @(negedge clk);
        #1 check("l3_rv_end", {b_vid_rvalid, b_ch_rvalid}, 0);

        // Reset with two reads in flight: they must never surface.
        @(negedge clk);
        b_vid_req = 1'b1; b_vid_addr = 15'h0012;
        #1 check("fl_gnt0", b_vid_gnt, 1);
        @(negedge clk);
        b_vid_addr = 15'h0013;
        #1 check("fl_gnt1", b_vid_gnt, 1);
        @(negedge clk);
        reset = 1'b1; a_ch_req = 2'b11;
        #1;
        check("fl_rst_gnt", {b_vid_gnt, b_ch_gnt, a_ch_gnt}, 0);
        check("fl_rst_rvalid", {b_vid_rvalid, b_ch_rvalid}, 0);
        check("fl_rst_mem_addr", b_mem_addr, 0);
        check("fl_rst_mem_we", b_mem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_all();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check("fl_no_rvalid", {b_vid_rvalid, b_ch_rvalid}, 0);
        end
        @(negedge clk);
        a_ch_req = 2'b11;
        #1 check("ptr_after_reset", a_ch_gnt, 2'b01);
        @(negedge clk);
        idle_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
